led_pwm_drive: RTL and testbench

Downstream LED output stage: consumes the 32-bit LED pattern register and drives the physical LED pins with global PWM brightness, optional per-bit blinking and polarity control. It is a naive_bus slave on the peripheral bus, in parallel with the pattern register. The pattern register's led[31:0] connects straight to led_in. The block drives the top-level LED pins directly.

---
 rtl/led_pwm_pkg.sv | 33 +++
 rtl/naive_bus.sv | 21 ++
 rtl/led_pwm_timebase.sv | 74 +++++++
 rtl/led_pwm_drive.sv | 136 +++++++++++++
 tb/tb_led_pwm_drive.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pwm_pkg.sv
// Shared constants for the LED PWM output stage: register map, duty width,
// CTRL bit positions, reset values and the DUTY write saturation helper.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    REG_CTRL       = 2'd0,
    REG_DUTY       = 2'd1,
    REG_BLINK_MASK = 2'd2,
    REG_BLINK_HALF = 2'd3
  } led_reg_e;

  localparam int DUTY_W       = 9;
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  localparam logic [DUTY_W-1:0] DUTY_FULL      = 9'd256;
  localparam logic [1:0]        CTRL_RST       = 2'b00;
  localparam logic [DUTY_W-1:0] DUTY_RST       = DUTY_FULL;
  localparam logic [31:0]       BLINK_MASK_RST = 32'h0000_0000;
  localparam logic [15:0]       BLINK_HALF_RST = 16'h0000;
  localparam logic [31:0]       LED_PIN_RST    = 32'h0000_0000;

  function automatic logic [DUTY_W-1:0] duty_sat(input logic [31:0] wdata);
    logic [DUTY_W-1:0] result;
    if (wdata > {23'd0, DUTY_FULL}) begin
      result = DUTY_FULL;
    end else begin
      result = wdata[DUTY_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/naive_bus.sv
// Simple peripheral bus: independent read and write request/grant channels.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/led_pwm_timebase.sv
// PWM timebase: clock prescaler, 8-bit PWM counter and the blink half-period
// counter with its phase flag. Emits a one-cycle strobe at every period wrap.
module led_pwm_timebase #(
  parameter int unsigned CLK_DIV = 195
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_blink_half,
  input  logic        i_blink_restart,
  output logic        o_wrap,
  output logic [7:0]  o_pwm_cnt,
  output logic        o_phase
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 32'd1);

  logic [15:0] r_presc;
  logic [7:0]  r_pwm_cnt;
  logic [15:0] r_blink_cnt;
  logic        r_phase;
  logic        w_tick;
  logic        w_wrap;
  logic        w_blink_on;
  logic        w_blink_hit;

  assign w_tick      = (r_presc == DIV_LAST);
  assign w_wrap      = w_tick && (r_pwm_cnt == 8'hFF);
  assign w_blink_on  = (i_blink_half != 16'd0);
  assign w_blink_hit = w_blink_on && (r_blink_cnt == (i_blink_half - 16'd1));

  // prescaler and PWM counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= 16'd0;
      r_pwm_cnt <= 8'd0;
    end else if (w_tick) begin
      r_presc   <= 16'd0;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end else begin
      r_presc   <= r_presc + 16'd1;
      r_pwm_cnt <= r_pwm_cnt;
    end
  end

  // blink half-period counter; a BLINK_HALF write restarts it in the on phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= 16'd0;
      r_phase     <= 1'b1;
    end else if (i_blink_restart) begin
      r_blink_cnt <= 16'd0;
      r_phase     <= 1'b1;
    end else if (w_wrap) begin
      if (w_blink_hit) begin
        r_blink_cnt <= 16'd0;
        r_phase     <= ~r_phase;
      end else if (w_blink_on) begin
        r_blink_cnt <= r_blink_cnt + 16'd1;
        r_phase     <= r_phase;
      end else begin
        r_blink_cnt <= 16'd0;
        r_phase     <= r_phase;
      end
    end else begin
      r_blink_cnt <= r_blink_cnt;
      r_phase     <= r_phase;
    end
  end

  assign o_wrap    = w_wrap;
  assign o_pwm_cnt = r_pwm_cnt;
  assign o_phase   = r_phase;

endmodule

// File: rtl/led_pwm_drive.sv
// LED output stage: bus register file, period-aligned duty shadow and the
// registered pin driver. Define LED_PWM_GAMMA_EN for quadratic duty mapping.
module led_pwm_drive
  import led_pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 195
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] led_in,
  output logic [31:0] led_pin,
  naive_bus.slave     bus
);

  logic [1:0]        r_ctrl;
  logic [DUTY_W-1:0] r_duty;
  logic [DUTY_W-1:0] r_duty_shadow;
  logic [31:0]       r_blink_mask;
  logic [15:0]       r_blink_half;
  logic [31:0]       r_rd_data;
  logic [31:0]       r_led_pin;

  led_reg_e          w_wr_sel;
  led_reg_e          w_rd_sel;
  logic [31:0]       w_rd_mux;
  logic              w_blink_restart;
  logic              w_wrap;
  logic [7:0]        w_pwm_cnt;
  logic              w_phase;
  logic [DUTY_W-1:0] w_duty_eff;
  logic              w_pwm_on;
  logic [31:0]       w_blink_gate;
  logic [31:0]       w_led_next;
  logic              w_unused;

  assign w_wr_sel        = led_reg_e'(bus.wr_addr[3:2]);
  assign w_rd_sel        = led_reg_e'(bus.rd_addr[3:2]);
  assign bus.wr_gnt      = bus.wr_req;
  assign bus.rd_gnt      = bus.rd_req;
  assign w_blink_restart = bus.wr_req && (w_wr_sel == REG_BLINK_HALF);
  assign w_unused        = ^{bus.wr_addr[31:4], bus.wr_addr[1:0],
                             bus.rd_addr[31:4], bus.rd_addr[1:0]};

  led_pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_blink_half    (r_blink_half),
    .i_blink_restart (w_blink_restart),
    .o_wrap          (w_wrap),
    .o_pwm_cnt       (w_pwm_cnt),
    .o_phase         (w_phase)
  );

  // register file writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl       <= CTRL_RST;
      r_duty       <= DUTY_RST;
      r_blink_mask <= BLINK_MASK_RST;
      r_blink_half <= BLINK_HALF_RST;
    end else if (bus.wr_req) begin
      case (w_wr_sel)
        REG_CTRL:       r_ctrl       <= bus.wr_data[1:0];
        REG_DUTY:       r_duty       <= duty_sat(bus.wr_data);
        REG_BLINK_MASK: r_blink_mask <= bus.wr_data;
        REG_BLINK_HALF: r_blink_half <= bus.wr_data[15:0];
        default:        r_ctrl       <= r_ctrl;
      endcase
    end else begin
      r_ctrl <= r_ctrl;
    end
  end

  // read mux over the stored (pre-write) register values
  always_comb begin
    w_rd_mux = 32'd0;
    case (w_rd_sel)
      REG_CTRL:       w_rd_mux = {30'd0, r_ctrl};
      REG_DUTY:       w_rd_mux = {23'd0, r_duty};
      REG_BLINK_MASK: w_rd_mux = r_blink_mask;
      REG_BLINK_HALF: w_rd_mux = {16'd0, r_blink_half};
      default:        w_rd_mux = 32'd0;
    endcase
  end

  // read data capture; holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= 32'd0;
    end else if (bus.rd_req) begin
      r_rd_data <= w_rd_mux;
    end else begin
      r_rd_data <= r_rd_data;
    end
  end

  assign bus.rd_data = r_rd_data;

  // duty shadow only moves on a period boundary so no period is ever split
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty_shadow <= DUTY_RST;
    end else if (w_wrap) begin
      r_duty_shadow <= r_duty;
    end else begin
      r_duty_shadow <= r_duty_shadow;
    end
  end

`ifdef LED_PWM_GAMMA_EN
  logic [16:0] w_duty_sq;
  assign w_duty_sq  = {8'd0, r_duty_shadow} * {8'd0, r_duty_shadow};
  assign w_duty_eff = w_duty_sq[16:8];
`else
  assign w_duty_eff = r_duty_shadow;
`endif

  assign w_pwm_on     = ({1'b0, w_pwm_cnt} < w_duty_eff);
  assign w_blink_gate = ~r_blink_mask | {32{w_phase | (r_blink_half == 16'd0)}};
  assign w_led_next   = {32{r_ctrl[CTRL_INV_BIT]}} ^
                        ({32{r_ctrl[CTRL_EN_BIT] & w_pwm_on}} & led_in & w_blink_gate);

  // pin output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_pin <= LED_PIN_RST;
    end else begin
      r_led_pin <= w_led_next;
    end
  end

  assign led_pin = r_led_pin;

endmodule

// File: tb/tb_led_pwm_drive.sv
// Directed self-checking bench for led_pwm_drive with CLK_DIV=2 (512-cycle period).
module tb_led_pwm_drive;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] led_in = 32'h0;
  logic [31:0] led_pin;
  int          n_tests = 0;
  int          n_fail = 0;

`ifdef LED_PWM_GAMMA_EN
  localparam int HI_DUTY64 = 32;
`else
  localparam int HI_DUTY64 = 128;
`endif

  naive_bus bus_if ();

  led_pwm_drive #(.CLK_DIV(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .led_in  (led_in),
    .led_pin (led_pin),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] data);
    @(posedge clk); #1;
    bus_if.wr_req  = 1'b1;
    bus_if.wr_addr = {28'd0, sel, 2'b00};
    bus_if.wr_data = data;
    @(posedge clk); #1;
    bus_if.wr_req  = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] sel, output logic [31:0] data);
    @(posedge clk); #1;
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = {28'd0, sel, 2'b00};
    @(posedge clk); #1;
    bus_if.rd_req  = 1'b0;
    data = bus_if.rd_data;
  endtask

  task automatic measure(input int n, output int hi, output int rises, output int bad);
    logic prev;
    hi = 0; rises = 0; bad = 0;
    @(posedge clk); #1;
    prev = led_pin[0];
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (led_pin[0]) hi++;
      if (led_pin[0] && !prev) rises++;
      if (led_pin !== 32'd0 && led_pin !== led_in) bad++;
      prev = led_pin[0];
    end
  endtask

  task automatic blink_measure(input int n, output int on_c, output int off_c,
                               output int max_off, output int bad);
    int run;
    on_c = 0; off_c = 0; max_off = 0; bad = 0; run = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (led_pin[31:4] !== led_in[31:4]) bad++;
      if (led_pin[3:0] === 4'hF) begin
        on_c++; run = 0;
      end else if (led_pin[3:0] === 4'h0) begin
        off_c++; run++;
        if (run > max_off) max_off = run;
      end else begin
        bad++;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    led_in = 32'hFFFF_FFFF;
    bus_write(2'd0, 32'h1);
    repeat (5) @(posedge clk);
    #3;
    n_tests++;
    if (led_pin !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL pre_reset_pin: got %h expected %h", led_pin, 32'hFFFF_FFFF);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (led_pin !== 32'h0) begin
      n_fail++; $display("FAIL reset_pin_async: got %h expected %h", led_pin, 32'h0);
    end
    #10;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_read(2'd0, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'd256) begin n_fail++; $display("FAIL reset_duty: got %h expected %h", d, 32'd256); end
    bus_read(2'd2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h expected %h", d, 32'h0); end
    bus_read(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_half: got %h expected %h", d, 32'h0); end
    n_tests++;
    if (led_pin !== 32'h0) begin n_fail++; $display("FAIL reset_pin_idle: got %h expected %h", led_pin, 32'h0); end
  endtask

  task automatic test_full_duty();
    int bad;
    led_in = 32'hA5A5_00FF;
    bus_write(2'd0, 32'h1);
    n_tests++;
    if (led_pin !== 32'h0) begin n_fail++; $display("FAIL full_latency: got %h expected %h", led_pin, 32'h0); end
    @(posedge clk); #1;
    n_tests++;
    if (led_pin !== 32'hA5A5_00FF) begin
      n_fail++; $display("FAIL full_first: got %h expected %h", led_pin, 32'hA5A5_00FF);
    end
    bad = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (led_pin !== 32'hA5A5_00FF) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL full_steady: got %0d bad cycles expected 0", bad); end
    bus_write(2'd0, 32'h3);
    @(posedge clk); #1;
    n_tests++;
    if (led_pin !== 32'h5A5A_FF00) begin
      n_fail++; $display("FAIL full_inv: got %h expected %h", led_pin, 32'h5A5A_FF00);
    end
    bus_write(2'd0, 32'h2);
    @(posedge clk); #1;
    n_tests++;
    if (led_pin !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL disabled_inv: got %h expected %h", led_pin, 32'hFFFF_FFFF);
    end
    bus_write(2'd0, 32'h1);
  endtask

  task automatic test_linear_duty();
    logic [31:0] d;
    int hi, rises, bad;
    bus_write(2'd1, 32'd64);
    @(posedge clk); #1;
    n_tests++;
    if (led_pin !== led_in) begin
      n_fail++; $display("FAIL duty_shadow_hold: got %h expected %h", led_pin, led_in);
    end
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'd64) begin n_fail++; $display("FAIL duty64_read: got %h expected %h", d, 32'd64); end
    repeat (600) @(posedge clk);
    measure(512, hi, rises, bad);
    n_tests++;
    if (hi !== HI_DUTY64) begin n_fail++; $display("FAIL duty64_high: got %0d expected %0d", hi, HI_DUTY64); end
    n_tests++;
    if (rises !== 1) begin n_fail++; $display("FAIL duty64_pulses: got %0d expected 1", rises); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL duty64_pattern: got %0d bad expected 0", bad); end
    bus_write(2'd1, 32'h3FF);
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'd256) begin n_fail++; $display("FAIL duty_sat_read: got %h expected %h", d, 32'd256); end
    repeat (600) @(posedge clk);
    measure(512, hi, rises, bad);
    n_tests++;
    if (hi !== 512) begin n_fail++; $display("FAIL duty_sat_high: got %0d expected 512", hi); end
    bus_write(2'd1, 32'd0);
    repeat (600) @(posedge clk);
    measure(512, hi, rises, bad);
    n_tests++;
    if (hi !== 0) begin n_fail++; $display("FAIL duty0_high: got %0d expected 0", hi); end
    bus_write(2'd1, 32'd256);
    repeat (600) @(posedge clk);
  endtask

  task automatic test_blink();
    logic [31:0] d;
    int on_c, off_c, max_off, bad, waited;
    led_in = 32'hA5A5_00FF;
    bus_write(2'd2, 32'h0000_000F);
    @(posedge clk); #1;
    n_tests++;
    if (led_pin !== led_in) begin n_fail++; $display("FAIL blink_half0: got %h expected %h", led_pin, led_in); end
    bus_write(2'd3, 32'd2);
    blink_measure(2048, on_c, off_c, max_off, bad);
    n_tests++;
    if (on_c !== 1024 || off_c !== 1024) begin
      n_fail++; $display("FAIL blink2_duty: got on %0d off %0d expected 1024 1024", on_c, off_c);
    end
    n_tests++;
    if (max_off !== 1024) begin n_fail++; $display("FAIL blink2_offrun: got %0d expected 1024", max_off); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL blink2_steady: got %0d bad expected 0", bad); end
    waited = 0;
    while (led_pin[3:0] !== 4'h0 && waited < 3000) begin
      @(posedge clk); #1;
      waited++;
    end
    n_tests++;
    if (waited >= 3000) begin n_fail++; $display("FAIL blink_wait_off: got timeout expected off phase"); end
    bus_write(2'd3, 32'd2);
    @(posedge clk); #1;
    n_tests++;
    if (led_pin !== led_in) begin n_fail++; $display("FAIL blink_restart: got %h expected %h", led_pin, led_in); end
    bus_read(2'd3, d);
    n_tests++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL blink_half_read: got %h expected %h", d, 32'd2); end
    bus_write(2'd3, 32'd1);
    blink_measure(2048, on_c, off_c, max_off, bad);
    n_tests++;
    if (on_c !== 1024 || off_c !== 1024 || max_off !== 512 || bad !== 0) begin
      n_fail++;
      $display("FAIL blink1: got on %0d off %0d run %0d bad %0d expected 1024 1024 512 0",
               on_c, off_c, max_off, bad);
    end
    bus_write(2'd3, 32'd0);
    blink_measure(1024, on_c, off_c, max_off, bad);
    n_tests++;
    if (off_c !== 0 || bad !== 0) begin
      n_fail++; $display("FAIL blink_disable: got off %0d bad %0d expected 0 0", off_c, bad);
    end
    bus_write(2'd2, 32'h0);
  endtask

  task automatic test_bus_corner();
    logic [31:0] d;
    @(posedge clk); #1;
    bus_if.rd_req  = 1'b1;
    bus_if.rd_addr = 32'h4;
    bus_if.wr_req  = 1'b1;
    bus_if.wr_addr = 32'h4;
    bus_if.wr_data = 32'd100;
    #1;
    n_tests++;
    if (bus_if.rd_gnt !== 1'b1 || bus_if.wr_gnt !== 1'b1) begin
      n_fail++; $display("FAIL corner_gnt: got rd %b wr %b expected 1 1", bus_if.rd_gnt, bus_if.wr_gnt);
    end
    @(posedge clk); #1;
    bus_if.rd_req = 1'b0;
    bus_if.wr_req = 1'b0;
    #1;
    n_tests++;
    if (bus_if.rd_gnt !== 1'b0 || bus_if.wr_gnt !== 1'b0) begin
      n_fail++; $display("FAIL corner_gnt_drop: got rd %b wr %b expected 0 0", bus_if.rd_gnt, bus_if.wr_gnt);
    end
    n_tests++;
    if (bus_if.rd_data !== 32'd256) begin
      n_fail++; $display("FAIL corner_old: got %h expected %h", bus_if.rd_data, 32'd256);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus_if.rd_data !== 32'd256) begin
      n_fail++; $display("FAIL corner_hold: got %h expected %h", bus_if.rd_data, 32'd256);
    end
    bus_read(2'd1, d);
    n_tests++;
    if (d !== 32'd100) begin n_fail++; $display("FAIL corner_new: got %h expected %h", d, 32'd100); end
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, d);
    n_tests++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL unused_ctrl: got %h expected %h", d, 32'h3); end
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, d);
    n_tests++;
    if (d !== 32'h0000_FFFF) begin n_fail++; $display("FAIL unused_half: got %h expected %h", d, 32'h0000_FFFF); end
    bus_write(2'd3, 32'h0);
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'd256);
    repeat (600) @(posedge clk);
  endtask

`ifdef LED_PWM_GAMMA_EN
  task automatic test_gamma();
    int hi, rises, bad;
    led_in = 32'hA5A5_00FF;
    bus_write(2'd1, 32'd128);
    repeat (600) @(posedge clk);
    measure(512, hi, rises, bad);
    n_tests++;
    if (hi !== 128) begin n_fail++; $display("FAIL gamma128: got %0d expected 128", hi); end
    bus_write(2'd1, 32'd15);
    repeat (600) @(posedge clk);
    measure(512, hi, rises, bad);
    n_tests++;
    if (hi !== 0) begin n_fail++; $display("FAIL gamma15: got %0d expected 0", hi); end
    bus_write(2'd1, 32'd256);
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus_if.rd_req  = 1'b0;
    bus_if.rd_addr = 32'h0;
    bus_if.wr_req  = 1'b0;
    bus_if.wr_addr = 32'h0;
    bus_if.wr_data = 32'h0;
    rst_n = 1'b0;
    #22;
    rst_n = 1'b1;
    test_reset();
    test_full_duty();
    test_linear_duty();
    test_blink();
    test_bus_corner();
`ifdef LED_PWM_GAMMA_EN
    test_gamma();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
